// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared state encoding, frame constants and fold helper for the RAM boot loader.
package ram_loader_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_SYNC1, S_CNT_HI, S_CNT_LO, S_DATA, S_WRITE, S_CSUM, S_VERIFY, S_BOOT, S_DONE, S_ERR
  } state_e;
  localparam logic [7:0] SYNC_A = 8'hA5;
  localparam logic [7:0] SYNC_B = 8'h5A;
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_COUNT = 2'd1;
  localparam logic [1:0] ERR_CSUM  = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;
  function automatic logic [7:0] fold32to8(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction
endpackage

// File: rtl/ram_boot_loader_byte_fetch.sv
// byte_fetch: single-outstanding FIFO pop handshake plus the mid-frame starvation timeout.
module byte_fetch #(
  parameter int TIMEOUT = 1000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       tmo_en_i,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd_en,
  output logic       byte_valid,
  output logic [7:0] byte_o,
  output logic       timeout_o
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic          pend_q, pend_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          starved;
  always_comb begin
    fifo_rd_en = !rst_i && en_i && !fifo_empty && !pend_q;
    pend_d = fifo_rd_en;
    starved = tmo_en_i && fifo_empty && !pend_q;
    timeout_o = starved && (tmo_q == TW'(TIMEOUT - 1));
    tmo_d = starved ? tmo_q + 1'b1 : '0;
  end
  assign byte_valid = pend_q;
  assign byte_o = fifo_dout;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
      tmo_q <= '0;
    end else begin
      pend_q <= pend_d;
      tmo_q <= tmo_d;
    end
  end
endmodule

// File: rtl/ram_boot_loader.sv
// ram_boot_loader: loads a framed byte stream into RAM0 while the CPU is stalled,
// verifies it by readback, then pulses CPU reset or flags an error.
module ram_boot_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int MAX_WORDS  = 65535,
  parameter int TIMEOUT    = 1000000,
  parameter int RST_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_dout,
  output logic        openRISC_STALL,
  output logic        RAM_WE,
  output logic [15:0] RAM_ADDR,
  output logic [31:0] RAM_DATA_I,
  input  logic [31:0] RAM_DATA_O,
  output logic        cpu_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);
  localparam logic [15:0] MAXW = 16'(MAX_WORDS);
  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d, rem_q, rem_d, cnt_n;
  logic [ADDR_W-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        bcnt_q, bcnt_d, code_q, code_d;
  logic [7:0]        csum_q, csum_d, rfold_q, rfold_d, fold_rd, rx_byte;
  logic              rv_q, rv_d, stall_q, stall_d, done_q, done_d, err_q, err_d;
  logic              rx_valid, timeout, fetch_en, tmo_en;
  assign fetch_en = state_q inside {S_IDLE, S_SYNC1, S_CNT_HI, S_CNT_LO, S_DATA, S_CSUM};
  assign tmo_en = state_q inside {[S_CNT_HI:S_CSUM]};
  byte_fetch #(.TIMEOUT(TIMEOUT)) u_fetch (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(fetch_en), .tmo_en_i(tmo_en),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .byte_valid(rx_valid), .byte_o(rx_byte), .timeout_o(timeout)
  );
  assign busy_o = state_q inside {[S_CNT_HI:S_BOOT]};
  assign openRISC_STALL = stall_q;
  assign RAM_WE = state_q == S_WRITE;
  assign RAM_ADDR = RAM_WE ? 16'(waddr_q) : 16'(raddr_q);
  assign RAM_DATA_I = word_q;
  assign cpu_rst_o = state_q == S_BOOT;
  assign done_o = done_q;
  assign err_o = err_q;
  assign err_code_o = code_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    word_d = word_q;
    bcnt_d = bcnt_q;
    csum_d = csum_q;
    rfold_d = rfold_q;
    rv_d = 1'b0;
    done_d = done_q;
    err_d = err_q;
    code_d = code_q;
    cnt_n = {cnt_q[15:8], rx_byte};
    fold_rd = rfold_q ^ (rv_q ? fold32to8(RAM_DATA_O) : 8'h00);
    case (state_q)
      S_IDLE: if (rx_valid && rx_byte == SYNC_A) state_d = S_SYNC1;
      S_SYNC1: if (rx_valid) begin
        if (rx_byte == SYNC_B) begin
          state_d = S_CNT_HI;
          done_d = 1'b0;
          err_d = 1'b0;
          code_d = ERR_NONE;
          csum_d = 8'h00;
          rfold_d = 8'h00;
          waddr_d = '0;
          raddr_d = '0;
          bcnt_d = 2'd0;
        end else if (rx_byte != SYNC_A) state_d = S_IDLE;
      end
      S_CNT_HI: if (rx_valid) begin
        cnt_d = {rx_byte, 8'h00};
        state_d = S_CNT_LO;
      end
      S_CNT_LO: if (rx_valid) begin
        cnt_d = cnt_n;
        rem_d = cnt_n;
        state_d = cnt_n > MAXW ? S_ERR : cnt_n == 16'd0 ? S_CSUM : S_DATA;
        code_d = cnt_n > MAXW ? ERR_COUNT : code_q;
      end
      S_DATA: if (rx_valid) begin
        word_d = {word_q[23:0], rx_byte};
        bcnt_d = bcnt_q + 2'd1;
        state_d = bcnt_q == 2'd3 ? S_WRITE : S_DATA;
      end
      S_WRITE: begin
        csum_d = csum_q ^ fold32to8(word_q);
        waddr_d = waddr_q + 1'b1;
        rem_d = rem_q - 16'd1;
        state_d = rem_q == 16'd1 ? S_CSUM : S_DATA;
      end
      S_CSUM: if (rx_valid) begin
        state_d = rx_byte == csum_q ? S_VERIFY : S_ERR;
        code_d = rx_byte == csum_q ? code_q : ERR_CSUM;
        rem_d = cnt_q;
      end
      // Reads are issued while rem_q != 0; the extra cycle collects the last registered word.
      S_VERIFY: begin
        rfold_d = fold_rd;
        if (rem_q != 16'd0) begin
          raddr_d = raddr_q + 1'b1;
          rem_d = rem_q - 16'd1;
          rv_d = 1'b1;
        end else if (fold_rd != csum_q) begin
          state_d = S_ERR;
          code_d = ERR_CSUM;
        end else begin
          state_d = S_BOOT;
          rem_d = 16'(RST_CYCLES - 1);
        end
      end
      S_BOOT: begin
        state_d = rem_q == 16'd0 ? S_DONE : S_BOOT;
        rem_d = rem_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout) begin
      state_d = S_ERR;
      code_d = ERR_TMO;
    end
    if (state_d == S_DONE) done_d = 1'b1;
    if (state_d == S_ERR) err_d = 1'b1;
    stall_d = busy_o && (state_d inside {[S_CNT_HI:S_BOOT]});
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      waddr_q <= '0;
      raddr_q <= '0;
      word_q <= '0;
      bcnt_q <= '0;
      csum_q <= '0;
      rfold_q <= '0;
      rv_q <= 1'b0;
      stall_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      code_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      word_q <= word_d;
      bcnt_q <= bcnt_d;
      csum_q <= csum_d;
      rfold_q <= rfold_d;
      rv_q <= rv_d;
      stall_q <= stall_d;
      done_q <= done_d;
      err_q <= err_d;
      code_q <= code_d;
    end
  end
endmodule

// File: tb/tb_ram_boot_loader.sv
// tb_ram_boot_loader: directed frames against a FIFO/RAM model with write and outcome scoreboards.
module tb_ram_boot_loader;
  localparam int TMO = 50;
  typedef struct packed {logic [15:0] addr; logic [31:0] data;} wr_t;
  typedef struct {logic done; logic err; logic [1:0] code; int rst_len; int delay;} out_t;
  logic        clk = 1'b0, rst_i = 1'b1, fifo_empty = 1'b1, fifo_rd_en;
  logic [7:0]  fifo_dout = 8'h00;
  logic        openRISC_STALL, RAM_WE, cpu_rst_o, busy_o, done_o, err_o;
  logic [15:0] RAM_ADDR;
  logic [31:0] RAM_DATA_I, RAM_DATA_O = 32'h0;
  logic [1:0]  err_code_o;
  logic [31:0] mem [0:8191];
  logic        corrupt = 1'b0, busy_prev = 1'b0, stall_prev = 1'b0;
  logic [7:0]  fq[$];
  wr_t         wq[$];
  out_t        oq[$];
  wr_t         ew;
  out_t        eo;
  int          checks = 0, passed = 0, cyc = 0, last_pop = 0, rst_len = 0, wr_cnt = 0, wc;

  ram_boot_loader #(.ADDR_W(13), .MAX_WORDS(8191), .TIMEOUT(TMO), .RST_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .openRISC_STALL(openRISC_STALL), .RAM_WE(RAM_WE),
    .RAM_ADDR(RAM_ADDR), .RAM_DATA_I(RAM_DATA_I), .RAM_DATA_O(RAM_DATA_O),
    .cpu_rst_o(cpu_rst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .err_code_o(err_code_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
    fifo_empty <= fq.size() == 0;
    if (RAM_WE) mem[RAM_ADDR[12:0]] <= (corrupt && RAM_ADDR == 16'd1) ? RAM_DATA_I ^ 32'h100 : RAM_DATA_I;
    RAM_DATA_O <= mem[RAM_ADDR[12:0]];
  end

  // Monitor: consumes the write and outcome scoreboards as the DUT produces them.
  always @(negedge clk) begin
    if (rst_i) begin
      busy_prev = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (fifo_rd_en) last_pop = cyc;
      if (busy_o && !busy_prev) rst_len = 0;
      if (cpu_rst_o) begin
        rst_len++;
        check("stall_during_boot", 32'(openRISC_STALL), 32'd1);
      end
      if (RAM_WE) begin
        wr_cnt++;
        check("stall_before_we", 32'(stall_prev), 32'd1);
        check("write_expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          ew = wq.pop_front();
          check("we_addr", 32'(RAM_ADDR), 32'(ew.addr));
          check("we_data", RAM_DATA_I, ew.data);
        end
      end
      if (busy_prev && !busy_o) begin
        check("outcome_expected", 32'(oq.size() != 0), 32'd1);
        if (oq.size() != 0) begin
          eo = oq.pop_front();
          check("done_o", 32'(done_o), 32'(eo.done));
          check("err_o", 32'(err_o), 32'(eo.err));
          check("err_code_o", 32'(err_code_o), 32'(eo.code));
          check("cpu_rst_len", 32'(rst_len), 32'(eo.rst_len));
          check("stall_released", 32'(openRISC_STALL), 32'd0);
          if (eo.delay >= 0) check("timeout_delay", 32'(cyc - last_pop), 32'(eo.delay));
        end
      end
      busy_prev = busy_o;
      stall_prev = openRISC_STALL;
    end
  end

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
  endtask

  task automatic frame(input bit full, input int n, input logic [31:0] w0, input logic [31:0] w1,
                       input logic [7:0] csum_err);
    logic [31:0] w;
    logic [7:0] cs;
    cs = 8'h00;
    if (full) push(8'hA5);
    push(8'h5A);
    push(8'(n >> 8));
    push(8'(n));
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : w1;
      for (int b = 3; b >= 0; b--) begin
        push(w[b*8 +: 8]);
        cs ^= w[b*8 +: 8];
      end
      wq.push_back(wr_t'{16'(i), w});
    end
    push(cs ^ csum_err);
  endtask

  task automatic expect_out(input logic d, input logic e, input logic [1:0] c, input int rl, input int dl);
    out_t o;
    o.done = d;
    o.err = e;
    o.code = c;
    o.rst_len = rl;
    o.delay = dl;
    oq.push_back(o);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (oq.size() == 0 && fq.size() == 0 && !busy_o) break;
    end
    check(tag, 32'(oq.size() + wq.size() + fq.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_stall", 32'(openRISC_STALL), 32'd0);
    check("rst_we", 32'(RAM_WE), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_flags", {29'd0, done_o, err_o, |err_code_o}, 32'd0);
    check("rst_addr", 32'(RAM_ADDR), 32'd0);
    @(negedge clk);
    #2 rst_i = 1'b0;
    // Two-word load with CSUM 0x88
    frame(1'b1, 2, 32'h11223344, 32'h55667788, 8'h00);
    expect_out(1'b1, 1'b0, 2'd0, 16, -1);
    wait_done("load2_complete");
    check("mem0", mem[0], 32'h11223344);
    check("mem1", mem[1], 32'h55667788);
    check("done_sticky", {30'd0, done_o, openRISC_STALL}, 32'd2);
    // Garbage then resync on the second A5
    push(8'h00);
    push(8'hA5);
    push(8'hA5);
    repeat (12) @(negedge clk);
    check("garbage_busy", 32'(busy_o), 32'd0);
    check("garbage_stall", 32'(openRISC_STALL), 32'd0);
    frame(1'b0, 1, 32'hDEADBEEF, 32'h0, 8'h00);
    expect_out(1'b1, 1'b0, 2'd0, 16, -1);
    wait_done("resync_complete");
    check("resync_mem0", mem[0], 32'hDEADBEEF);
    // Count above MAX_WORDS
    wc = wr_cnt;
    push(8'hA5);
    push(8'h5A);
    push(8'hFF);
    push(8'hFF);
    expect_out(1'b0, 1'b1, 2'd1, 0, -1);
    wait_done("count_complete");
    check("count_no_writes", 32'(wr_cnt - wc), 32'd0);
    // Bad checksum byte: word still written
    frame(1'b1, 1, 32'hCAFEF00D, 32'h0, 8'h01);
    expect_out(1'b0, 1'b1, 2'd2, 0, -1);
    wait_done("csum_complete");
    check("csum_mem0", mem[0], 32'hCAFEF00D);
    // RAM corrupts word 1 so the readback fold differs
    corrupt = 1'b1;
    frame(1'b1, 2, 32'h01020304, 32'hA0B0C0D0, 8'h00);
    expect_out(1'b0, 1'b1, 2'd2, 0, -1);
    wait_done("verify_complete");
    corrupt = 1'b0;
    // Starve after three data bytes: ERR lands TMO empty cycles after the last byte is consumed
    push(8'hA5);
    push(8'h5A);
    push(8'h00);
    push(8'h02);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    expect_out(1'b0, 1'b1, 2'd3, 0, TMO + 2);
    wait_done("timeout_complete");
    // Async reset in DATA, then a clean load
    push(8'hA5);
    push(8'h5A);
    push(8'h00);
    push(8'h01);
    push(8'h11);
    push(8'h22);
    repeat (16) @(negedge clk);
    check("abort_busy_before", 32'(busy_o), 32'd1);
    @(posedge clk);
    #2 rst_i = 1'b1;
    #1;
    check("abort_stall", 32'(openRISC_STALL), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_we", 32'(RAM_WE), 32'd0);
    check("abort_cpu_rst", 32'(cpu_rst_o), 32'd0);
    @(negedge clk);
    #2 rst_i = 1'b0;
    frame(1'b1, 1, 32'h12345678, 32'h0, 8'h00);
    expect_out(1'b1, 1'b0, 2'd0, 16, -1);
    wait_done("reload_complete");
    check("reload_mem0", mem[0], 32'h12345678);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ram_boot_loader.md
Name: ram_boot_loader

Overview:
- Producer-side driver of the RAM0 FIFO write port (openRISC_STALL / RAM_WE / RAM_ADDR / RAM_DATA_I / RAM_DATA_O) on ram0_top.
- Consumes a framed byte stream from a host-link RX FIFO and stalls the OR1200 while it loads.
- Writes big-endian 32-bit words into RAM0, then reads them back and compares checksums.
- On success, pulses CPU reset and releases the stall. On failure, flags an error and releases the stall without a reset.

Parameters:
- ADDR_W, 16, RAM word-address width; 16 for 64K words, 13 for 8K words.
- MAX_WORDS, 65535, largest word count accepted. The GPIO word (all-ones address) is never written when MAX_WORDS = 2^ADDR_W-1.
- TIMEOUT, 1000000, idle cycles allowed with the FIFO empty mid-frame before abort.
- RST_CYCLES, 16, length of the cpu_rst_o pulse.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- fifo_empty  in  1  RX FIFO empty
- fifo_rd_en  out  1  FIFO pop; data is valid on fifo_dout the cycle after the pop
- fifo_dout  in  8  FIFO read data
- openRISC_STALL  out  1  holds the CPU and gives this block ownership of the RAM0 port
- RAM_WE  out  1  RAM write enable, full 32-bit word
- RAM_ADDR  out  16  word address; bits above ADDR_W are driven 0
- RAM_DATA_I  out  32  write data into RAM0
- RAM_DATA_O  in  32  RAM0 read data; registered RAM, so one-cycle read latency
- cpu_rst_o  out  1  CPU reset pulse after a successful load
- busy_o  out  1  frame in progress
- done_o  out  1  sticky; last frame loaded and verified
- err_o  out  1  sticky; last frame failed
- err_code_o  out  2  failure cause: 1 = count too large, 2 = checksum mismatch, 3 = timeout

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, all counters cleared.
- Frame format: 0xA5, 0x5A, CNT_HI, CNT_LO, then CNT×4 data bytes (MSB first per word), then CSUM. CSUM is the XOR of all data bytes.
- FIFO read rule: at most one outstanding pop. fifo_rd_en is asserted only when !fifo_empty and no byte is pending. Each byte is consumed the cycle after its pop.
- IDLE → SYNC1 on byte 0xA5; any other byte is discarded.
- SYNC1: byte 0x5A goes to CNT_HI. Byte 0xA5 stays in SYNC1. Any other byte returns to IDLE.
- Entering CNT_HI:
  - busy_o = 1.
  - done_o and err_o clear.
  - openRISC_STALL rises the next cycle and stays high until the frame exits.
- CNT_LO: count is latched.
  - Count > MAX_WORDS → ERR with code 1.
  - Count = 0 → CSUM.
  - Otherwise → DATA with address 0.
- DATA: bytes shift into a 32-bit word register. On the 4th byte → WRITE.
- WRITE: one cycle with RAM_WE = 1, RAM_ADDR = current address, RAM_DATA_I = assembled word.
  - Running XOR checksum of the data bytes is updated.
  - Address increments; a second 8-bit fold, written-word XOR-folded to 8 bits, is also accumulated.
  - Next state: last word → CSUM, else DATA.
- CSUM: received byte ≠ running XOR → ERR with code 2. Otherwise → VERIFY.
- VERIFY: read back addresses 0..CNT-1 with RAM_WE = 0, one address per cycle, pipelined.
  - RAM_DATA_O sampled at cycle N+1 belongs to the address driven at cycle N.
  - Each readback word is XOR-folded into an 8-bit readback fold.
  - After the final sample: folds mismatch → ERR with code 2. Match → BOOT.
- BOOT: cpu_rst_o = 1 for RST_CYCLES cycles while the stall stays high. Then → DONE.
- DONE: one cycle. Stall = 0, busy_o = 0, done_o = 1. → IDLE.
- ERR: one cycle. Stall = 0, busy_o = 0, err_o = 1, err_code_o latched, no cpu_rst_o. → IDLE.
- Stall/RAM ordering: openRISC_STALL is high at least one cycle before the first RAM_WE, and at least one cycle after the last RAM access.
- Outside WRITE, RAM_WE is always 0.
- Timeout: in any state from CNT_HI to CSUM, TIMEOUT consecutive cycles with the FIFO empty and no byte pending → ERR with code 3. The counter clears on every consumed byte.
- Address arithmetic: ADDR_W bits wide, wraps modulo 2^ADDR_W. Wrap cannot occur when MAX_WORDS < 2^ADDR_W.
- Asynchronous reset mid-frame: immediately drops the stall, RAM_WE and cpu_rst_o. Partially written RAM contents are left as they are.

Decomposition:
- Package ram_loader_pkg:
  - FSM state encoding.
  - Sync bytes 0xA5 / 0x5A.
  - Error-code constants.
  - Function fold32to8 (XOR of 4 bytes).
- One sub-module, byte_fetch: the FIFO pop/valid handshake plus the timeout counter. It presents byte_valid / byte to the main FSM.

Test Plan:
- Frame A5 5A 00 02 | 11 22 33 44 | 55 66 77 88 | CSUM 0x88 →
  - RAM[0] = 0x11223344, RAM[1] = 0x55667788.
  - VERIFY passes; cpu_rst_o high for 16 cycles.
  - done_o = 1, err_o = 0, stall low afterwards.
- Garbage bytes 00 A5 A5 5A then a valid 1-word frame → sync recovers on the second A5 and the load succeeds. The stall never rises before CNT_HI.
- Count 0xFFFF with MAX_WORDS = 8191 → err_o = 1, err_code_o = 1, zero RAM writes, stall released.
- Valid 1-word frame with a wrong CSUM byte → err_code_o = 2, no cpu_rst_o. The word is still written to RAM[0].
- RAM model corrupts RAM[1] on write → readback folds mismatch → err_code_o = 2, no cpu_rst_o.
- FIFO starves after 3 data bytes with TIMEOUT = 50 → err_code_o = 3 after exactly 50 empty cycles.
- Async reset during DATA → stall and busy_o drop in the same cycle. A following valid frame loads correctly.
